// File: rtl/seq_pkg.sv
// Shared types and default constants for the match window counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        COUNT  = 2'b01,
        REPORT = 2'b10
    } state_e;

    localparam int WIN_LEN_DEF = 16;
    localparam int CNT_W_DEF   = 8;
    localparam int THRESH_DEF  = 3;

endpackage

// File: rtl/seq_win_timer.sv
// Window position counter: clears on clr_i, advances on inc_i, flags the last cycle.
// Latency: last_o is decoded from the registered count (valid in the same cycle).
// Backpressure: none; the owner decides when to advance or clear.
// Ports: clk, rst_n (async active-low), clr_i, inc_i, last_o.
module seq_win_timer #(
    parameter int WIN_LEN = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    logic [WIN_W-1:0] win_cnt_q;
    logic [WIN_W-1:0] win_cnt_d;

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (clr_i) begin
            win_cnt_d = '0;
        end else if (inc_i) begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
        end
    end

    assign last_o = (win_cnt_q == WIN_W'(WIN_LEN - 1));

endmodule

// File: rtl/seq_match_window_counter.sv
// Counts detector matches over WIN_LEN-cycle windows and reports each window's count.
// Latency: result valid one cycle after the last counted window cycle.
// Backpressure: result held in REPORT until cnt_valid & cnt_ready; matches seen meanwhile set missed.
// Ports: clk, rst_n, en, det_in in; cnt_out/cnt_valid/alarm/overflow result with cnt_ready;
//        missed (sticky, cleared at window start) and busy status out.
module seq_match_window_counter
    import seq_pkg::*;
#(
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int THRESH  = THRESH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             det_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             alarm,
    output logic             overflow,
    output logic             missed,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             ovf_flag_q, ovf_flag_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic             cnt_valid_q, cnt_valid_d;
    logic             alarm_q, alarm_d;
    logic             overflow_q, overflow_d;
    logic             missed_q, missed_d;

    logic             timer_clr;
    logic             timer_inc;
    logic             win_last;
    logic             sat;
    logic [CNT_W-1:0] match_nxt;
    logic             ovf_nxt;

    // The timer is held at zero outside COUNT, so every window starts at position 0.
    seq_win_timer #(
        .WIN_LEN (WIN_LEN)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (timer_clr),
        .inc_i  (timer_inc),
        .last_o (win_last)
    );

    always_comb begin
        // Saturating count including this cycle's match; a match at saturation marks overflow.
        sat       = (match_cnt_q == CNT_MAX);
        match_nxt = (det_in && !sat) ? match_cnt_q + CNT_W'(1) : match_cnt_q;
        ovf_nxt   = ovf_flag_q | (det_in & sat);

        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        ovf_flag_d  = ovf_flag_q;
        cnt_out_d   = cnt_out_q;
        cnt_valid_d = cnt_valid_q;
        alarm_d     = alarm_q;
        overflow_d  = overflow_q;
        missed_d    = missed_q;
        timer_clr   = 1'b1;
        timer_inc   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d     = COUNT;
                    match_cnt_d = '0;
                    ovf_flag_d  = 1'b0;
                    missed_d    = 1'b0;
                end
            end
            COUNT: begin
                timer_clr = 1'b0;
                if (!en) begin
                    // Abort: partial window discarded, this cycle's match not counted.
                    state_d = IDLE;
                end else begin
                    timer_inc   = 1'b1;
                    match_cnt_d = match_nxt;
                    ovf_flag_d  = ovf_nxt;
                    if (win_last) begin
                        state_d     = REPORT;
                        cnt_out_d   = match_nxt;
                        cnt_valid_d = 1'b1;
                        alarm_d     = (32'(match_nxt) >= THRESH);
                        overflow_d  = ovf_nxt;
                    end
                end
            end
            REPORT: begin
                if (det_in) begin
                    missed_d = 1'b1;
                end
                if (cnt_valid_q && cnt_ready) begin
                    cnt_valid_d = 1'b0;
                    alarm_d     = 1'b0;
                    overflow_d  = 1'b0;
                    if (en) begin
                        // New window start wins over a match seen in the handshake cycle.
                        state_d     = COUNT;
                        match_cnt_d = '0;
                        ovf_flag_d  = 1'b0;
                        missed_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            match_cnt_q <= '0;
            ovf_flag_q  <= 1'b0;
            cnt_out_q   <= '0;
            cnt_valid_q <= 1'b0;
            alarm_q     <= 1'b0;
            overflow_q  <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            ovf_flag_q  <= ovf_flag_d;
            cnt_out_q   <= cnt_out_d;
            cnt_valid_q <= cnt_valid_d;
            alarm_q     <= alarm_d;
            overflow_q  <= overflow_d;
            missed_q    <= missed_d;
        end
    end

    assign cnt_out   = cnt_out_q;
    assign cnt_valid = cnt_valid_q;
    assign alarm     = alarm_q;
    assign overflow  = overflow_q;
    assign missed    = missed_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_match_window_counter.sv
module tb_seq_match_window_counter;

    localparam int WIN = 16;
    localparam int THR = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       det_in;
    logic       cnt_ready;

    logic [7:0] cnt_out;
    logic       cnt_valid, alarm, overflow, missed, busy;
    logic [1:0] cnt_out2;
    logic       cnt_valid2, alarm2, overflow2, missed2, busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_match_window_counter #(.WIN_LEN(WIN), .CNT_W(8), .THRESH(THR)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .det_in(det_in),
        .cnt_out(cnt_out), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
        .alarm(alarm), .overflow(overflow), .missed(missed), .busy(busy)
    );

    seq_match_window_counter #(.WIN_LEN(WIN), .CNT_W(2), .THRESH(THR)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .det_in(det_in),
        .cnt_out(cnt_out2), .cnt_valid(cnt_valid2), .cnt_ready(cnt_ready),
        .alarm(alarm2), .overflow(overflow2), .missed(missed2), .busy(busy2)
    );

    logic [12:0] obs1, obs2;
    assign obs1 = {cnt_out, cnt_valid, alarm, overflow, missed, busy};
    assign obs2 = {6'b0, cnt_out2, cnt_valid2, alarm2, overflow2, missed2, busy2};

    // Reference model: index 0 = 8-bit counter, index 1 = 2-bit counter.
    // m_phase: -1 idle, 0..WIN-1 samples taken so far in the window, WIN = awaiting readout.
    int m_phase[2];
    int m_sum[2];
    int m_cnt[2];
    bit m_valid[2], m_alarm[2], m_ovf[2], m_missed[2];
    int m_max[2] = '{255, 3};

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = -1; m_sum[i] = 0; m_cnt[i] = 0;
            m_valid[i] = 0; m_alarm[i] = 0; m_ovf[i] = 0; m_missed[i] = 0;
        end
    endfunction

    function automatic void model_step(bit e, bit d, bit r);
        for (int i = 0; i < 2; i++) begin
            if (m_phase[i] < 0) begin
                if (e) begin
                    m_phase[i] = 0; m_sum[i] = 0; m_missed[i] = 0;
                end
            end else if (m_phase[i] < WIN) begin
                if (!e) begin
                    m_phase[i] = -1;
                end else begin
                    m_sum[i] += int'(d);
                    m_phase[i]++;
                    if (m_phase[i] == WIN) begin
                        m_cnt[i]   = (m_sum[i] > m_max[i]) ? m_max[i] : m_sum[i];
                        m_ovf[i]   = (m_sum[i] > m_max[i]);
                        m_alarm[i] = (m_cnt[i] >= THR);
                        m_valid[i] = 1;
                    end
                end
            end else begin
                if (d) m_missed[i] = 1;
                if (r) begin
                    m_valid[i] = 0; m_alarm[i] = 0; m_ovf[i] = 0;
                    if (e) begin
                        m_phase[i] = 0; m_sum[i] = 0; m_missed[i] = 0;
                    end else begin
                        m_phase[i] = -1;
                    end
                end
            end
        end
    endfunction

    function automatic logic [12:0] model_vec(int i);
        return {8'(m_cnt[i]), m_valid[i], m_alarm[i], m_ovf[i], m_missed[i], (m_phase[i] != -1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(en, det_in, cnt_ready);
        #1;
    endtask

    // Enter COUNT if idle, then drive one full window with det_in taken from mask bit k on window cycle k.
    task automatic run_window(input logic [15:0] mask);
        en = 1'b1; cnt_ready = 1'b0; det_in = 1'b0;
        if (m_phase[0] < 0) tick();
        for (int k = 0; k < WIN; k++) begin
            det_in = mask[k];
            tick();
        end
        det_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; det_in = 1'b0; cnt_ready = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            det_in = ~det_in;
            tick();
            checks++;
            if (obs1 !== 13'd0 || obs2 !== 13'd0) begin
                errors++;
                $display("FAIL reset_outputs: got %h/%h exp 0", obs1, obs2);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            det_in = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (obs1 !== 13'd0 || obs2 !== 13'd0) begin
                errors++;
                $display("FAIL idle_outputs cyc %0d: got %h/%h exp 0", k, obs1, obs2);
            end
        end
    endtask

    task automatic test_threshold();
        run_window(16'h0248);
        checks++;
        if ({cnt_out, cnt_valid, alarm, overflow} !== {8'd3, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL thresh_result: got cnt=%0d v=%b a=%b o=%b exp cnt=3 v=1 a=1 o=0",
                     cnt_out, cnt_valid, alarm, overflow);
        end
        tick();
        checks++;
        if (obs1 !== model_vec(0)) begin
            errors++;
            $display("FAIL thresh_hold: got %h exp %h", obs1, model_vec(0));
        end
        cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
        checks++;
        if ({cnt_valid, alarm, busy, cnt_out} !== {1'b0, 1'b0, 1'b1, 8'd3}) begin
            errors++;
            $display("FAIL thresh_handshake: got v=%b a=%b busy=%b cnt=%0d exp v=0 a=0 busy=1 cnt=3",
                     cnt_valid, alarm, busy, cnt_out);
        end
    endtask

    task automatic test_window_edges();
        run_window(16'h8001);
        checks++;
        if ({cnt_out, cnt_valid, alarm} !== {8'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL edges_result: got cnt=%0d v=%b a=%b exp cnt=2 v=1 a=0", cnt_out, cnt_valid, alarm);
        end
    endtask

    task automatic test_report_hold();
        cnt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            det_in = (k == 1);
            tick();
            checks++;
            if ({cnt_out, cnt_valid} !== {8'd2, 1'b1}) begin
                errors++;
                $display("FAIL hold_stable cyc %0d: got cnt=%0d v=%b exp cnt=2 v=1", k, cnt_out, cnt_valid);
            end
        end
        det_in = 1'b0;
        checks++;
        if (missed !== 1'b1) begin
            errors++;
            $display("FAIL hold_missed: got %b exp 1", missed);
        end
        en = 1'b1; cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
        checks++;
        if ({missed, cnt_valid, busy} !== {1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL hold_newwin: got missed=%b v=%b busy=%b exp 0 0 1", missed, cnt_valid, busy);
        end
    endtask

    task automatic test_saturation();
        run_window(16'hFFFF);
        checks++;
        if ({cnt_out2, overflow2, alarm2, cnt_valid2} !== {2'd3, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sat_narrow: got cnt=%0d o=%b a=%b v=%b exp 3 1 1 1", cnt_out2, overflow2, alarm2, cnt_valid2);
        end
        checks++;
        if ({cnt_out, overflow, alarm} !== {8'd16, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sat_wide: got cnt=%0d o=%b a=%b exp 16 0 1", cnt_out, overflow, alarm);
        end
        en = 1'b0; cnt_ready = 1'b1;
        tick();
        cnt_ready = 1'b0;
        checks++;
        if ({busy, cnt_valid, overflow2, cnt_out} !== {1'b0, 1'b0, 1'b0, 8'd16}) begin
            errors++;
            $display("FAIL sat_to_idle: got busy=%b v=%b o2=%b cnt=%0d exp 0 0 0 16", busy, cnt_valid, overflow2, cnt_out);
        end
    endtask

    task automatic test_abort();
        en = 1'b1; det_in = 1'b0; cnt_ready = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) begin
            det_in = 1'($urandom_range(0, 1));
            tick();
        end
        en = 1'b0; det_in = 1'b1;
        tick();
        det_in = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b exp 0", busy);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (cnt_valid !== 1'b0 || obs1 !== model_vec(0)) begin
                errors++;
                $display("FAIL abort_novalid cyc %0d: got %h exp %h", k, obs1, model_vec(0));
            end
        end
    endtask

    task automatic test_async_reset();
        run_window(16'h0111);
        checks++;
        if ({cnt_valid, alarm} !== 2'b11) begin
            errors++;
            $display("FAIL areset_pre: got v=%b a=%b exp 1 1", cnt_valid, alarm);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cnt_valid, alarm, busy, cnt_valid2, alarm2} !== 5'b0) begin
            errors++;
            $display("FAIL areset_async: got v=%b a=%b busy=%b v2=%b a2=%b exp all 0",
                     cnt_valid, alarm, busy, cnt_valid2, alarm2);
        end
        model_reset();
        #1 rst_n = 1'b1;
        en = 1'b0;
        tick();
        checks++;
        if (obs1 !== 13'd0) begin
            errors++;
            $display("FAIL areset_after: got %h exp 0", obs1);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            en        = ($urandom_range(0, 15) != 0);
            det_in    = ($urandom_range(0, 3) == 0);
            cnt_ready = ($urandom_range(0, 2) == 0);
            tick();
            checks++;
            if (obs1 !== model_vec(0)) begin
                errors++;
                $display("FAIL rnd_wide cyc %0d: got %h exp %h", cyc, obs1, model_vec(0));
            end
            checks++;
            if (obs2 !== model_vec(1)) begin
                errors++;
                $display("FAIL rnd_narrow cyc %0d: got %h exp %h", cyc, obs2, model_vec(1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_window_edges();
        test_report_hold();
        test_saturation();
        test_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_match_window_counter.md
Name: seq_match_window_counter

Overview:
- Downstream consumer of the Moore "1001" sequence detector: samples the detector's one-cycle match output and counts matches over fixed windows of WIN_LEN cycles.
- Presents each window's count to a reader over a valid/ready handshake, with a threshold alarm and saturation and missed-match flags.
- Sits between the detector output and the status/readout logic.

Parameters:
- WIN_LEN, 16, window length in clk cycles; legal range >= 2.
- CNT_W, 8, width of the match count; count saturates at 2^CNT_W-1.
- THRESH, 3, alarm when final window count >= THRESH.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  counting enable; windows run only while high.
- det_in  in  1  detector match output; one match per cycle it is high.
- cnt_out  out  CNT_W  final match count of the last completed window.
- cnt_valid  out  1  cnt_out/alarm/overflow are valid.
- cnt_ready  in  1  reader accepts the result.
- alarm  out  1  final count >= THRESH; qualified by cnt_valid.
- overflow  out  1  count saturated during the reported window; qualified by cnt_valid.
- missed  out  1  sticky: det_in was high while the block was not counting (REPORT state).
- busy  out  1  high in COUNT or REPORT.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; cnt_out=0, cnt_valid=0, alarm=0, overflow=0, missed=0, busy=0; all internal counters 0. Takes effect immediately, including mid-window and mid-REPORT.
- All outputs are registered; there is no combinational path from input to output.
- States: IDLE, COUNT, REPORT.
- IDLE:
  - det_in ignored; missed unaffected.
  - en=1 -> COUNT next cycle; win_cnt=0, match_cnt=0, overflow flag=0, missed=0.
- COUNT:
  - Each cycle win_cnt increments; width is $clog2(WIN_LEN).
  - det_in=1 -> match_cnt+1, saturating at 2^CNT_W-1. An increment attempt at saturation sets the internal overflow flag.
  - en=0 in any COUNT cycle -> abort to IDLE next cycle. No report; partial count discarded; det_in in that cycle not counted.
  - On cycle win_cnt==WIN_LEN-1 with en=1, det_in of that cycle is counted. Next cycle: REPORT, with:
    - cnt_out = final match_cnt
    - alarm = (final >= THRESH)
    - overflow = internal flag
    - cnt_valid = 1
  - A window therefore spans exactly WIN_LEN COUNT cycles; cnt_valid rises 1 cycle after the last counted cycle.
- REPORT:
  - cnt_out, alarm, overflow and cnt_valid are held stable until handshake (cnt_valid & cnt_ready).
  - det_in=1 in REPORT -> missed=1 (sticky). The match is not counted.
  - en is ignored until handshake. Deasserting en during REPORT does not drop cnt_valid.
  - Handshake cycle:
    - cnt_valid, alarm, overflow clear next cycle; cnt_out retains its value.
    - If en=1: COUNT next cycle with counters cleared; missed clears at the start of the new window.
    - If en=0: IDLE; missed holds until the next window start.
  - cnt_ready while cnt_valid=0 has no effect.
- Simultaneous events: det_in on the final COUNT cycle is counted. det_in in the handshake cycle counts as REPORT (sets missed), not as part of the new window.
- busy = (state != IDLE).

Decomposition:
- Shared package seq_pkg:
  - state typedef: IDLE=2'b00, COUNT=2'b01, REPORT=2'b10.
  - default constants WIN_LEN_DEF=16, CNT_W_DEF=8, THRESH_DEF=3.
- One natural sub-module, seq_win_timer: clear/enable window counter with a last-cycle flag, parameterised by WIN_LEN.
- FSM, saturating counter and result registers live in the top module.

Test Plan (WIN_LEN=16, THRESH=3 unless stated):
1. rst_n=0 for 2 cycles with det_in toggling -> all outputs 0, busy=0. Release rst_n, en=0 for 10 cycles -> outputs stay 0.
2. en=1; det_in pulses on window cycles 3, 6, 9 -> cnt_valid=1 after 16 COUNT cycles, cnt_out=3, alarm=1, overflow=0. cnt_ready=1 one cycle later -> cnt_valid=0 next cycle, next window begins.
3. Pulses on window cycles 0 and 15 only -> cnt_out=2, alarm=0. Confirms both window edges are counted.
4. Hold cnt_ready=0 for 5 cycles in REPORT, det_in pulse on the 2nd of those cycles -> cnt_out/cnt_valid stable, missed=1. Handshake with en=1 -> missed=0 on the next cycle.
5. CNT_W=2, det_in=1 for all 16 cycles -> cnt_out=3, overflow=1, alarm=1.
6. en dropped at window cycle 7 -> IDLE, cnt_valid never asserts. Separately, rst_n pulsed low mid-REPORT -> cnt_valid and alarm fall asynchronously before the next clk edge.
